// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU-side read port of the buffered UART receiver.
interface uart_rx_if;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;
  modport master (output rx_rd, input rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy);
  modport slave  (input rx_rd, output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a one-byte holding register and sticky error flags.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 217,
  parameter int HALF_BIT     = 108
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  uart_rx_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'(HALF_BIT);
  state_t     state, state_n;
  logic       s1, rxd_s;
  logic [7:0] cnt, shift, data;
  logic [2:0] idx;
  logic       tick, dlv, ferr_set, valid, overrun, frame_err;
  assign tick = (state == START && cnt == HALF) || ((state == DATA || state == STOP) && cnt == LAST);
  assign ferr_set = state == STOP && tick && !rxd_s;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rxd_s ? IDLE : START;
      START:     state_n = tick ? (rxd_s ? IDLE : DATA) : START;
      DATA:      state_n = (tick && idx == 3'd7) ? STOP : DATA;
      STOP:      state_n = tick ? (rxd_s ? IDLE : WAIT_IDLE) : STOP;
      WAIT_IDLE: state_n = rxd_s ? IDLE : WAIT_IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {s1, rxd_s} <= 2'b11;
    end else begin
      state <= state_n;
      {s1, rxd_s} <= {rxd, s1};
    end
  end
  // Counter restarts on every state change and every sample point, so sample
  // positions are measured from the synchronised start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      dlv   <= 1'b0;
    end else begin
      cnt <= (tick || state_n != state || state == IDLE) ? '0 : cnt + 8'd1;
      idx <= state == START ? '0 : (state == DATA && tick) ? idx + 3'd1 : idx;
      if (state == DATA && tick) shift[idx] <= rxd_s;
      dlv <= state == STOP && tick && rxd_s;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      data      <= (dlv && (!valid || bus.rx_rd)) ? shift : data;
      valid     <= dlv ? 1'b1 : bus.rx_rd ? 1'b0 : valid;
      overrun   <= bus.rx_rd ? 1'b0 : (dlv && valid) ? 1'b1 : overrun;
      frame_err <= ferr_set ? 1'b1 : bus.rx_rd ? 1'b0 : frame_err;
    end
  end
  assign bus.rx_data      = data;
  assign bus.rx_valid     = valid;
  assign bus.rx_overrun   = overrun;
  assign bus.rx_frame_err = frame_err;
  assign bus.rx_busy      = state != IDLE;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed frames at 217 clk/bit with hand-computed expectations.
module tb_uart_rx_buffered;
  localparam int BIT = 217;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  int checks = 0;
  int passed = 0;
  uart_rx_if bus();
  uart_rx_buffered dut (.clk(clk), .rst_n(rst_n), .rxd(rxd), .bus(bus.slave));
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int extra, input logic stop);
    rxd = 1'b0;
    cycles(BIT + extra);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cycles(BIT);
    end
    rxd = stop;
    cycles(BIT);
  endtask

  task automatic rd();
    @(negedge clk) bus.rx_rd = 1'b1;
    @(negedge clk) bus.rx_rd = 1'b0;
  endtask

  task automatic flags(input string tag, input logic v, input logic o, input logic f, input logic b);
    chk({tag, "_valid"}, {7'd0, bus.rx_valid}, {7'd0, v});
    chk({tag, "_overrun"}, {7'd0, bus.rx_overrun}, {7'd0, o});
    chk({tag, "_frame_err"}, {7'd0, bus.rx_frame_err}, {7'd0, f});
    chk({tag, "_busy"}, {7'd0, bus.rx_busy}, {7'd0, b});
  endtask

  initial begin
    bus.rx_rd = 1'b0;
    cycles(5);
    chk("reset_data", bus.rx_data, 8'h00);
    flags("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    cycles(10);

    send(8'h38, 0, 1'b1);
    chk("b38_data", bus.rx_data, 8'h38);
    flags("b38", 1, 0, 0, 0);
    rd();
    flags("b38_rd", 0, 0, 0, 0);
    chk("b38_hold", bus.rx_data, 8'h38);

    send(8'h2A, 25, 1'b1);
    chk("b2a_data", bus.rx_data, 8'h2A);
    flags("b2a", 1, 0, 0, 0);
    rd();

    send(8'h39, 0, 1'b1);
    send(8'h37, 0, 1'b1);
    chk("ovr_data", bus.rx_data, 8'h39);
    flags("ovr", 1, 1, 0, 0);
    rd();
    flags("ovr_rd", 0, 0, 0, 0);

    send(8'h55, 0, 1'b0);
    cycles(3 * BIT);
    flags("brk", 0, 0, 1, 1);
    chk("brk_data", bus.rx_data, 8'h39);
    rxd = 1'b1;
    cycles(5);
    flags("brk_end", 0, 0, 1, 0);
    send(8'hA5, 0, 1'b1);
    chk("a5_data", bus.rx_data, 8'hA5);
    flags("a5", 1, 0, 1, 0);
    rd();
    flags("a5_rd", 0, 0, 0, 0);

    rxd = 1'b0;
    cycles(50);
    chk("glitch_busy", {7'd0, bus.rx_busy}, 8'd1);
    rxd = 1'b1;
    cycles(300);
    flags("glitch", 0, 0, 0, 0);
    send(8'hC3, 0, 1'b1);
    chk("c3_data", bus.rx_data, 8'hC3);

    rxd = 1'b0;
    cycles(BIT);
    rxd = 1'b1;
    cycles(4 * BIT + 100);
    chk("mid_busy", {7'd0, bus.rx_busy}, 8'd1);
    rst_n = 1'b0;
    cycles(3);
    chk("midrst_data", bus.rx_data, 8'h00);
    flags("midrst", 0, 0, 0, 0);
    rst_n = 1'b1;
    cycles(5 * BIT);
    flags("post_rst", 0, 0, 0, 0);
    chk("post_rst_data", bus.rx_data, 8'h00);
    send(8'h41, 0, 1'b1);
    chk("b41_data", bus.rx_data, 8'h41);
    flags("b41", 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
